// File: rtl/cpu_pkg.sv
// Shared types and constants for the ALU issue/writeback sequencer.
package cpu_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned NREGS = 4;

  localparam int unsigned OP_MSB = 6;
  localparam int unsigned OP_LSB = 4;
  localparam int unsigned RD_MSB = 3;
  localparam int unsigned RD_LSB = 2;
  localparam int unsigned RS_MSB = 1;
  localparam int unsigned RS_LSB = 0;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_LDI = 3'b101,
    OP_MOV = 3'b110,
    OP_NOP = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  // ALU opcodes share their encoding with ALU_Sel and occupy the low end of the space.
  function automatic logic is_alu_op(opcode_e op);
    return op <= OP_XOR;
  endfunction

endpackage

// File: rtl/alu_sequencer_if.sv
// Instruction handshake, ALU operand/result bus and writeback status of the sequencer.
interface alu_sequencer_if #(parameter int unsigned WIDTH = cpu_pkg::WIDTH);
  logic             instr_valid;
  logic             instr_ready;
  logic [6:0]       instr;
  logic [WIDTH-1:0] imm;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_out;
  logic             alu_carry;
  logic             result_valid;
  logic [WIDTH-1:0] result_data;
  logic             carry_flag;
  logic             zero_flag;

  modport master (
    output instr_valid, instr, imm, alu_out, alu_carry,
    input  instr_ready, alu_a, alu_b, alu_sel, result_valid, result_data,
           carry_flag, zero_flag
  );

  modport slave (
    input  instr_valid, instr, imm, alu_out, alu_carry,
    output instr_ready, alu_a, alu_b, alu_sel, result_valid, result_data,
           carry_flag, zero_flag
  );
endinterface

// File: rtl/reg_file_4x8.sv
// 4-entry register file: two operand read ports, one debug read port, one synchronous write.
module reg_file_4x8
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = cpu_pkg::WIDTH,
  parameter int unsigned NREGS = cpu_pkg::NREGS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ra_addr_i,
  input  logic [1:0]       rb_addr_i,
  input  logic [1:0]       dbg_addr_i,
  output logic [WIDTH-1:0] ra_data_o,
  output logic [WIDTH-1:0] rb_data_o,
  output logic [WIDTH-1:0] dbg_data_o,
  input  logic             we_i,
  input  logic [1:0]       wa_i,
  input  logic [WIDTH-1:0] wd_i
);

  logic [WIDTH-1:0] regs_q [NREGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign ra_data_o  = regs_q[ra_addr_i];
  assign rb_data_o  = regs_q[rb_addr_i];
  assign dbg_data_o = regs_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback stage around an external combinational ALU: latches operands at
// accept, writes the ALU result (or immediate / move source) back one cycle later.
module alu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = cpu_pkg::WIDTH,
  parameter int unsigned NREGS = cpu_pkg::NREGS
) (
  input  logic             clk,
  input  logic             rst,
  alu_sequencer_if.slave   bus,
  input  logic [1:0]       dbg_addr,
  output logic [WIDTH-1:0] dbg_data
);

  state_e           state_q;
  opcode_e          op_q;
  logic [1:0]       rd_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [2:0]       alu_sel_q;
  logic             result_valid_q;
  logic [WIDTH-1:0] result_data_q;
  logic             carry_q;
  logic             zero_q;

  logic             accept;
  opcode_e          op_in;
  logic [1:0]       rd_in;
  logic [1:0]       rs_in;
  logic [WIDTH-1:0] ra_data;
  logic [WIDTH-1:0] rb_data;
  logic             wb_en_d;
  logic [WIDTH-1:0] wb_data_d;

  assign op_in  = opcode_e'(bus.instr[OP_MSB:OP_LSB]);
  assign rd_in  = bus.instr[RD_MSB:RD_LSB];
  assign rs_in  = bus.instr[RS_MSB:RS_LSB];
  assign accept = bus.instr_valid && (state_q != EXEC);

  // Writeback happens at the EXEC-ending edge; the register file sees it the same edge.
  always_comb begin
    wb_en_d   = (state_q == EXEC) && (op_q != OP_NOP);
    wb_data_d = bus.alu_out;
    case (op_q)
      OP_LDI:  wb_data_d = imm_q;
      OP_MOV:  wb_data_d = alu_b_q;
      default: wb_data_d = bus.alu_out;
    endcase
  end

  reg_file_4x8 #(
    .WIDTH (WIDTH),
    .NREGS (NREGS)
  ) u_regs (
    .clk        (clk),
    .rst        (rst),
    .ra_addr_i  (rd_in),
    .rb_addr_i  (rs_in),
    .dbg_addr_i (dbg_addr),
    .ra_data_o  (ra_data),
    .rb_data_o  (rb_data),
    .dbg_data_o (dbg_data),
    .we_i       (wb_en_d),
    .wa_i       (rd_q),
    .wd_i       (wb_data_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      op_q           <= OP_NOP;
      rd_q           <= '0;
      imm_q          <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_sel_q      <= '0;
      result_valid_q <= 1'b0;
      result_data_q  <= '0;
      carry_q        <= 1'b0;
      zero_q         <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        EXEC: begin
          state_q        <= DONE;
          result_valid_q <= 1'b1;
          if (wb_en_d) begin
            result_data_q <= wb_data_d;
          end
          if (is_alu_op(op_q)) begin
            carry_q <= bus.alu_carry;
            zero_q  <= (bus.alu_out == '0);
          end
        end
        default: begin
          if (accept) begin
            state_q   <= EXEC;
            op_q      <= op_in;
            rd_q      <= rd_in;
            imm_q     <= bus.imm;
            alu_a_q   <= ra_data;
            alu_b_q   <= rb_data;
            alu_sel_q <= op_in;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.instr_ready  = (state_q != EXEC);
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_sel      = alu_sel_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result_data  = result_data_q;
  assign bus.carry_flag   = carry_q;
  assign bus.zero_flag    = zero_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural 8-bit ALU beside it.
module tb_alu_sequencer;
  import cpu_pkg::*;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  alu_sequencer_if #(.WIDTH(8)) bus ();

  alu_sequencer #(.WIDTH(8), .NREGS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU beside the sequencer: carry is bit 8 of the 9-bit add/subtract, 0 for logic ops.
  always_comb begin
    logic [8:0] t;
    case (bus.alu_sel)
      3'd0:    t = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'd1:    t = {1'b0, bus.alu_a} - {1'b0, bus.alu_b};
      3'd2:    t = {1'b0, bus.alu_a & bus.alu_b};
      3'd3:    t = {1'b0, bus.alu_a | bus.alu_b};
      3'd4:    t = {1'b0, bus.alu_a ^ bus.alu_b};
      default: t = '0;
    endcase
    bus.alu_out   = t[7:0];
    bus.alu_carry = t[8];
  end

  int n_cmp = 0;
  int n_err = 0;
  int n_pulse = 0;
  int n_expect = 0;

  logic [9:0] sb [$];
  logic [7:0] m_r [4];
  logic       m_c, m_z;
  logic [7:0] m_res;
  logic       prev_rv;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic read_reg(input logic [1:0] idx, output logic [7:0] val);
    dbg_addr = idx;
    #1;
    val = dbg_data;
  endtask

  task automatic check_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
    logic [7:0] v;
    read_reg(idx, v);
    check(tag, 32'(v), 32'(exp));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = '0;
    m_c = 1'b0;
    m_z = 1'b0;
    m_res = '0;
  endtask

  // Called at a negedge; returns at the negedge inside EXEC. Valid stays high.
  task automatic issue(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [7:0] imm, output int waits);
    logic [7:0] a, b, r;
    logic [8:0] t;
    bus.instr_valid = 1'b1;
    bus.instr       = {op, rd, rs};
    bus.imm         = imm;
    waits = 0;
    while (!bus.instr_ready && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.instr_ready) check("ready_timeout", 32'(bus.instr_ready), 32'd1);
    @(posedge clk);
    a = m_r[rd];
    b = m_r[rs];
    case (op)
      3'd0, 3'd1, 3'd2, 3'd3, 3'd4: begin
        case (op)
          3'd0:    t = {1'b0, a} + {1'b0, b};
          3'd1:    t = {1'b0, a} - {1'b0, b};
          3'd2:    t = {1'b0, a & b};
          3'd3:    t = {1'b0, a | b};
          default: t = {1'b0, a ^ b};
        endcase
        r = t[7:0];
        m_r[rd] = r;
        m_c = t[8];
        m_z = (r == 8'h00);
        m_res = r;
      end
      3'd5: begin m_r[rd] = imm; m_res = imm; end
      3'd6: begin m_r[rd] = b;   m_res = b;   end
      default: ;
    endcase
    sb.push_back({m_res, m_c, m_z});
    n_expect++;
    @(negedge clk);
    check("ready_in_exec", 32'(bus.instr_ready), 32'd0);
  endtask

  task automatic idle(input int n);
    bus.instr_valid = 1'b0;
    bus.instr = $urandom_range(0, 127);
    bus.imm   = $urandom_range(0, 255);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.result_valid) begin
      logic [9:0] e;
      n_pulse++;
      check("rv_single_cycle", 32'(prev_rv), 32'd0);
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("sb_result", {22'd0, bus.result_data, bus.carry_flag, bus.zero_flag}, {22'd0, e});
      end
    end
    prev_rv = bus.result_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    prev_rv = 1'b0;
    rst = 1'b1;
    dbg_addr = '0;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    bus.imm = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_ready", 32'(bus.instr_ready), 32'd1);
    check("rst_outputs", {bus.alu_a, bus.alu_b, 5'd0, bus.alu_sel},
          32'd0);
    check("rst_status", {22'd0, bus.result_data, bus.carry_flag, bus.zero_flag}, 32'd0);
    check("rst_rv", 32'(bus.result_valid), 32'd0);
    for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i), 8'h00);
    rst = 1'b0;
    @(negedge clk);

    // 1: basic add
    issue(3'd5, 2'd0, 2'd0, 8'h15, w); idle(2);
    issue(3'd5, 2'd1, 2'd0, 8'h0A, w); idle(2);
    issue(3'd0, 2'd0, 2'd1, 8'h00, w); idle(2);
    check_reg("t1_r0", 2'd0, 8'h1F);
    check("t1_flags", {30'd0, bus.carry_flag, bus.zero_flag}, 32'd0);

    // 2: carry out, then LDI preserves flags
    issue(3'd5, 2'd2, 2'd0, 8'hFF, w); idle(1);
    issue(3'd5, 2'd3, 2'd0, 8'hFF, w); idle(1);
    issue(3'd0, 2'd2, 2'd3, 8'h00, w); idle(2);
    check_reg("t2_r2", 2'd2, 8'hFE);
    check("t2_carry", 32'(bus.carry_flag), 32'd1);
    issue(3'd5, 2'd1, 2'd0, 8'h00, w); idle(2);
    check("t2_carry_kept", 32'(bus.carry_flag), 32'd1);

    // 3: zero flag set and cleared
    issue(3'd5, 2'd0, 2'd0, 8'hFF, w); idle(1);
    issue(3'd5, 2'd1, 2'd0, 8'hFF, w); idle(1);
    issue(3'd4, 2'd0, 2'd1, 8'h00, w); idle(2);
    check_reg("t3_r0", 2'd0, 8'h00);
    check("t3_zero", 32'(bus.zero_flag), 32'd1);
    issue(3'd5, 2'd2, 2'd0, 8'hF0, w); idle(1);
    issue(3'd5, 2'd3, 2'd0, 8'h0F, w); idle(1);
    issue(3'd3, 2'd2, 2'd3, 8'h00, w); idle(2);
    check_reg("t3_r2", 2'd2, 8'hFF);
    check("t3_zero_clr", 32'(bus.zero_flag), 32'd0);

    // 4: back-to-back with valid held high; each follow-on waits exactly one cycle
    issue(3'd5, 2'd0, 2'd0, 8'h15, w);
    issue(3'd5, 2'd1, 2'd0, 8'h0A, w); check("t4_b2b_wait", 32'(w), 32'd1);
    issue(3'd1, 2'd0, 2'd1, 8'h00, w); check("t4_b2b_wait", 32'(w), 32'd1);
    issue(3'd0, 2'd3, 2'd0, 8'h00, w); check("t4_b2b_wait", 32'(w), 32'd1);
    issue(3'd3, 2'd2, 2'd1, 8'h00, w); check("t4_b2b_wait", 32'(w), 32'd1);
    idle(2);
    check_reg("t4_r0", 2'd0, 8'h0B);
    check_reg("t4_r3", 2'd3, 8'h1A);

    // 5: reset in the middle of EXEC drops the instruction
    issue(3'd0, 2'd0, 2'd1, 8'h00, w);
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    n_expect--;
    model_reset();
    for (int i = 0; i < 4; i++) check_reg("t5_reg", 2'(i), 8'h00);
    check("t5_flags", {30'd0, bus.carry_flag, bus.zero_flag}, 32'd0);
    check("t5_rv", 32'(bus.result_valid), 32'd0);
    bus.instr_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("t5_ready", 32'(bus.instr_ready), 32'd1);
    idle(3);

    // 6: MOV and NOP leave flags alone; NOP keeps result_data
    issue(3'd5, 2'd2, 2'd0, 8'h80, w); idle(1);
    issue(3'd0, 2'd2, 2'd2, 8'h00, w); idle(1);
    issue(3'd5, 2'd0, 2'd0, 8'h5A, w); idle(1);
    issue(3'd6, 2'd3, 2'd0, 8'h00, w); idle(1);
    issue(3'd7, 2'd1, 2'd2, 8'h33, w); idle(2);
    check_reg("t6_r3", 2'd3, 8'h5A);
    check_reg("t6_r1", 2'd1, 8'h00);
    check("t6_flags", {30'd0, bus.carry_flag, bus.zero_flag}, 32'd3);
    check("t6_result", 32'(bus.result_data), 32'h5A);

    idle(3);
    check("sb_drain", 32'(sb.size()), 32'd0);
    check("pulse_count", 32'(n_pulse), 32'(n_expect));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
